// File: rtl/seg7_pkg.sv
// seg7_pkg: recorder state encoding and active-low 7-segment glyphs (bit order gfedcba)
package seg7_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_REC   = 3'd2,
    ST_PLAY  = 3'd3,
    ST_PAUSE = 3'd4
  } rec_state_e;

  localparam logic [6:0] G_0 = 7'h40, G_1 = 7'h79, G_2 = 7'h24, G_3 = 7'h30, G_4 = 7'h19;
  localparam logic [6:0] G_5 = 7'h12, G_6 = 7'h02, G_7 = 7'h78, G_8 = 7'h00, G_9 = 7'h10;
  localparam logic [6:0] G_I = 7'h4F, G_D = 7'h21, G_L = 7'h47, G_E = 7'h06, G_H = 7'h09;
  localparam logic [6:0] G_O = 7'h40, G_R = 7'h2F, G_C = 7'h46, G_P = 7'h0C, G_A = 7'h08;
  localparam logic [6:0] G_Y = 7'h11, G_U = 7'h41, G_S = 7'h12;
  localparam logic [6:0] G_DASH = 7'h3F, G_NULL = 7'h7F;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0: return G_0;
      4'd1: return G_1;
      4'd2: return G_2;
      4'd3: return G_3;
      4'd4: return G_4;
      4'd5: return G_5;
      4'd6: return G_6;
      4'd7: return G_7;
      4'd8: return G_8;
      4'd9: return G_9;
      default: return G_NULL;
    endcase
  endfunction
endpackage

// File: rtl/seg7_bin2bcd_seq.sv
// seg7_bin2bcd_seq: shift-add-3 converter of the top N bits of i_bin, one bit per cycle,
// result saturated to all nines when it does not fit in TIME_DIGITS digits
module seg7_bin2bcd_seq #(
  parameter int W = 20,
  parameter int N = 5,
  parameter int TIME_DIGITS = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [W-1:0]               i_bin,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [4*TIME_DIGITS-1:0]   o_bcd
);
  localparam int ND = ((N + 2) / 3 > TIME_DIGITS) ? (N + 2) / 3 : TIME_DIGITS;
  localparam int CW = $clog2(N + 1);

  logic [W-1:0]    sh;
  logic [4*ND-1:0] bcd, adj;
  logic [CW-1:0]   cnt;
  logic            sat;

  always_comb begin
    adj = bcd;
    sat = 1'b0;
    for (int i = 0; i < ND; i++) begin
      adj[4*i+:4] = bcd[4*i+:4] > 4'd4 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
      sat = sat | (i >= TIME_DIGITS && bcd[4*i+:4] != 4'd0);
    end
  end

  assign o_done = o_busy && cnt == '0;
  assign o_bcd  = sat ? {TIME_DIGITS{4'd9}} : bcd[4*TIME_DIGITS-1:0];

  // The whole word is loaded and shifted out MSB-first, so only its top N bits reach the BCD
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_busy <= 1'b0;
      cnt    <= '0;
      sh     <= '0;
      bcd    <= '0;
    end else if (i_start) begin
      o_busy <= 1'b1;
      cnt    <= CW'(N);
      sh     <= i_bin;
      bcd    <= '0;
    end else if (o_done) begin
      o_busy <= 1'b0;
    end else if (o_busy) begin
      sh  <= sh << 1;
      bcd <= (adj << 1) | (4*ND)'(sh[W-1]);
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/seg7_status_display.sv
// seg7_status_display: recorder status text, speed and elapsed-seconds 7-segment display.
// Define SEG7_BLINK_EN to blink the time and speed glyphs while paused.
module seg7_status_display import seg7_pkg::*; #(
  parameter int ADDR_W      = 20,
  parameter int ADDR_SHIFT  = 15,
  parameter int TIME_DIGITS = 2,
  parameter int REFRESH_CYC = 500000,
  parameter int BLINK_TICKS = 25
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [2:0]               i_state,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [2:0]               i_speed,
  input  logic                     i_slow,
  output logic [27:0]              o_seg_text,
  output logic [13:0]              o_seg_speed,
  output logic [7*TIME_DIGITS-1:0] o_seg_time,
  output logic                     o_busy
);
  localparam int SEC_W = ADDR_W - ADDR_SHIFT;
  localparam int RW    = $clog2(REFRESH_CYC);

  logic [RW-1:0]            rcnt;
  logic [2:0]               st_q;
  logic [27:0]              text_n;
  logic [13:0]              speed_n, speed_q;
  logic [7*TIME_DIGITS-1:0] time_q;
  logic [4*TIME_DIGITS-1:0] bcd;
  logic                     tick, done, hide, time_on, show_speed;

  assign tick       = rcnt == RW'(REFRESH_CYC - 1);
  assign show_speed = i_state == ST_PLAY || i_state == ST_PAUSE;
  assign speed_n    = show_speed ? {i_slow ? G_DASH : G_NULL, digit_glyph({1'b0, i_speed} + 4'd1)} : '1;
  assign time_on    = st_q == ST_REC || st_q == ST_PLAY || st_q == ST_PAUSE;

  always_comb
    case (i_state)
      ST_IDLE:  text_n = {G_I, G_D, G_L, G_E};
      ST_HOLD:  text_n = {G_H, G_O, G_L, G_D};
      ST_REC:   text_n = {G_NULL, G_R, G_E, G_C};
      ST_PLAY:  text_n = {G_P, G_L, G_A, G_Y};
      ST_PAUSE: text_n = {G_P, G_A, G_U, G_S};
      default:  text_n = '1;
    endcase

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rcnt       <= '0;
      st_q       <= 3'd7;
      o_seg_text <= '1;
      speed_q    <= '1;
      time_q     <= '1;
    end else begin
      rcnt       <= tick ? '0 : rcnt + 1'b1;
      st_q       <= i_state;
      o_seg_text <= text_n;
      speed_q    <= speed_n;
      if (done)
        for (int i = 0; i < TIME_DIGITS; i++)
          time_q[7*i+:7] <= digit_glyph(bcd[4*i+:4]);
    end

  seg7_bin2bcd_seq #(
    .W(ADDR_W),
    .N(SEC_W),
    .TIME_DIGITS(TIME_DIGITS)
  ) u_bcd (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(tick),
    .i_bin(i_addr),
    .o_busy(o_busy),
    .o_done(done),
    .o_bcd(bcd)
  );

`ifdef SEG7_BLINK_EN
  localparam logic [0:0] SHOW = 1'b0, HIDE = 1'b1;
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [0:0]    blink;
  logic [BW-1:0] bcnt;
  logic          bwrap;

  assign bwrap = bcnt == BW'(BLINK_TICKS - 1);
  assign hide  = blink == HIDE;

  // The cycle that enters PAUSE restarts the phase, so a coinciding tick is not counted
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      blink <= SHOW;
      bcnt  <= '0;
    end else if (i_state != ST_PAUSE || st_q != ST_PAUSE) begin
      blink <= SHOW;
      bcnt  <= '0;
    end else if (tick) begin
      bcnt  <= bwrap ? '0 : bcnt + 1'b1;
      blink <= bwrap ? ~blink : blink;
    end
`else
  assign hide = 1'b0;
`endif

  assign o_seg_speed = hide ? '1 : speed_q;
  assign o_seg_time  = time_on && !hide ? time_q : '1;
endmodule

// File: doc/seg7_status_display.md
SEG7_STATUS_DISPLAY -- requirements
Module: seg7_status_display

Interface
REQ-001 Parameter ADDR_W, default 20, width of the SRAM address input.
REQ-002 Parameter ADDR_SHIFT, default 15, log2 of samples per second; seconds = i_addr >> ADDR_SHIFT.
REQ-003 Parameter TIME_DIGITS, default 2, number of decimal time digits shown.
REQ-004 Parameter REFRESH_CYC, default 500000, clock cycles per refresh tick; legal values are >= 16.
REQ-005 Parameter BLINK_TICKS, default 25, refresh ticks per blink half-period.
REQ-006 i_clk  in  1  system clock; the only clock.
REQ-007 i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_state  in  3  recorder state: 0 IDLE, 1 HOLD, 2 REC, 3 PLAY, 4 PAUSE; 5-7 invalid.
REQ-009 i_addr  in  ADDR_W  current SRAM sample address.
REQ-010 i_speed  in  3  speed magnitude minus 1 (0 -> 1x ... 7 -> 8x).
REQ-011 i_slow  in  1  1 = slow-down (1/N), 0 = speed-up (N).
REQ-012 o_seg_text  out  28  four active-low glyphs; [27:21] is the leftmost glyph.
REQ-013 o_seg_speed  out  14  sign glyph [13:7], digit glyph [6:0].
REQ-014 o_seg_time  out  7*TIME_DIGITS  decimal seconds, most significant digit highest.
REQ-015 o_busy  out  1  high while a BCD conversion is in progress.

Function
REQ-016 Text: IDLE "IdLE", HOLD "HOLd", REC " rEC", PLAY "PLAY", PAUSE "PAUS"; an invalid state blanks every output (7'h7F per glyph).
REQ-017 Text and speed outputs are registered and follow i_state, i_speed and i_slow with exactly 1 cycle of latency.
REQ-018 Speed is shown only in PLAY and PAUSE: the digit is i_speed+1, and the sign glyph is "-" when i_slow=1 and blank when i_slow=0.
REQ-019 Speed is blanked in every other state.
REQ-020 Time is shown in REC, PLAY and PAUSE, and is blanked in IDLE and HOLD.
REQ-021 Refresh counter: counts 0..REFRESH_CYC-1 and wraps; the wrap cycle is the refresh tick.
REQ-022 On each tick, seconds are sampled from i_addr and a sequential conversion is started; o_busy rises on the next cycle.
REQ-023 The conversion is shift-add-3, one bit per cycle, taking ADDR_W-ADDR_SHIFT cycles.
REQ-024 o_seg_time and o_busy update together on the completion cycle.
REQ-025 If seconds exceed 10^TIME_DIGITS-1, every time digit shows 9 (saturation).
REQ-026 Changes to i_addr between ticks are ignored; the time display changes only at conversion completion.
REQ-027 Leading zeros are displayed (5 s shows "05").
REQ-028 Blink FSM states are SHOW and HIDE.
REQ-029 Blink FSM: entering PAUSE forces SHOW and clears the blink tick count.
REQ-030 Blink FSM: every BLINK_TICKS ticks the state toggles SHOW <-> HIDE.
REQ-031 In HIDE, time and speed glyphs are blanked and text is unaffected.
REQ-032 Leaving PAUSE forces SHOW.
REQ-033 A state change that coincides with a tick has its 1-cycle text update and the sampling for that tick's conversion both take effect.
REQ-034 A new tick never arrives mid-conversion, guaranteed by REQ-004.

Reset
REQ-035 Asserting i_rst_n low immediately sets every glyph output to 7'h7F.
REQ-036 Asserting i_rst_n low immediately sets o_busy=0, the refresh counter to 0, the blink FSM to SHOW and the blink count to 0.
REQ-037 A reset during a conversion aborts it and leaves no partial result.
REQ-038 After reset release, the first time value appears REFRESH_CYC + ADDR_W-ADDR_SHIFT + 1 cycles later.

Configuration
REQ-039 With the macro SEG7_BLINK_EN defined, blinking in PAUSE behaves per REQ-028..REQ-032.
REQ-040 Without SEG7_BLINK_EN, the blink FSM and its counter are not built and PAUSE displays are steady.

Structure
REQ-041 Package seg7_pkg holds the state enum and the glyph constants: letters, digits 0-9, dash and NULL.
REQ-042 Sub-module seg7_bin2bcd_seq holds the sequential converter, with start/busy/done handshake and a TIME_DIGITS parameter.

Verification
REQ-043 Reset: with i_rst_n low, every glyph output reads 7'h7F and o_busy=0.
REQ-044 Text latency: i_state 0 -> 3 produces "PLAY" on the next cycle; i_state=6 blanks all outputs on the next cycle.
REQ-045 Time: i_addr=20'h28000 in REC shows "05" after a tick plus 5 cycles; i_addr=20'hFFFFF shows "31".
REQ-046 Saturation: TIME_DIGITS=1 with i_addr=20'h60000 (12 s) shows "9".
REQ-047 Speed: PLAY with i_speed=3, i_slow=1 shows "-4"; with i_slow=0 it shows blank then "4".
REQ-048 Blink: with SEG7_BLINK_EN, REFRESH_CYC=16 and BLINK_TICKS=2, PAUSE shows time for 32 cycles, blanks it for 32 cycles, and leaving PAUSE restores it at once.
